term_char_writer: RTL



---
 rtl/term_pkg.sv | 17 +
 rtl/term_char_writer_if.sv | 23 ++
 rtl/term_char_writer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/term_pkg.sv
// Shared constants and state type for the terminal character writer.
package term_pkg;

  localparam int DEF_COLS = 40;
  localparam int DEF_ROWS = 24;

  localparam logic [5:0] CH_SPACE = 6'h20;
  localparam logic [6:0] ASCII_CR = 7'h0D;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    WRITE,
    CLEAR_LINE
  } state_t;

endpackage

// File: rtl/term_char_writer_if.sv
// Host character handshake plus the slot/load bus of the recirculating store.
interface term_char_writer_if;

  logic       char_valid;
  logic [6:0] char_data;
  logic       char_ready;
  logic       slot_tick;
  logic [5:0] slot_col;
  logic [4:0] slot_row;
  logic       mem_rc;
  logic [5:0] mem_data;

  modport master (
    output char_valid, char_data, slot_tick, slot_col, slot_row,
    input  char_ready, mem_rc, mem_data
  );

  modport slave (
    input  char_valid, char_data, slot_tick, slot_col, slot_row,
    output char_ready, mem_rc, mem_data
  );

endinterface

// File: rtl/term_char_writer.sv
// Cursor tracking and one-slot character injection into the recirculating
// character store, with newline, scroll and power-up screen clear.
module term_char_writer
  import term_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic                clk,
  input  logic                reset,
  term_char_writer_if.slave   bus,
  output logic [4:0]          top_row,
  output logic [5:0]          cur_col,
  output logic [4:0]          cur_row
);

  localparam logic [9:0] LAST_ALL  = 10'(ROWS * COLS - 1);
  localparam logic [9:0] LAST_LINE = 10'(COLS - 1);
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);

  state_t     state_reg, state_next;
  logic [4:0] top_row_reg, top_row_next;
  logic [5:0] cur_col_reg, cur_col_next;
  logic [4:0] cur_row_reg, cur_row_next;
  logic [5:0] code_reg, code_next;
  logic [9:0] cnt_reg, cnt_next;
  logic       char_ready_reg;
  logic       wr_hit;
  logic [4:0] nl_row;
  logic       nl_scroll;

  function automatic logic [4:0] row_inc(input logic [4:0] r);
    return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
  endfunction

  // Lower-case range folds onto upper case by subtracting 0x20.
  function automatic logic [5:0] fold_code(input logic [6:0] d);
    return (d >= 7'h60) ? 6'(d - 7'h20) : d[5:0];
  endfunction

  function automatic logic slot_hit(input logic tick, input logic [5:0] sc,
                                    input logic [4:0] sr, input logic [5:0] c,
                                    input logic [4:0] r);
    return tick && (sc == c) && (sr == r);
  endfunction

  assign nl_row    = row_inc(cur_row_reg);
  assign nl_scroll = (nl_row == top_row_reg);

  always_comb begin
    state_next   = state_reg;
    top_row_next = top_row_reg;
    cur_col_next = cur_col_reg;
    cur_row_next = cur_row_reg;
    code_next    = code_reg;
    cnt_next     = cnt_reg;
    wr_hit       = 1'b0;

    case (state_reg)
      CLEAR_ALL: begin
        // The first load is anchored at slot (0,0); after that every tick loads.
        if (bus.slot_tick && (cnt_reg != 10'd0 ||
            (bus.slot_col == 6'd0 && bus.slot_row == 5'd0))) begin
          wr_hit = 1'b1;
          if (cnt_reg == LAST_ALL) begin
            cnt_next   = 10'd0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 10'd1;
          end
        end
      end

      IDLE: begin
        if (bus.char_valid && char_ready_reg) begin
          if (bus.char_data == ASCII_CR) begin
            cur_col_next = 6'd0;
            cur_row_next = nl_row;
            if (nl_scroll) begin
              top_row_next = row_inc(top_row_reg);
              state_next   = CLEAR_LINE;
            end
          end else if (bus.char_data >= 7'h20) begin
            code_next  = fold_code(bus.char_data);
            state_next = WRITE;
          end
        end
      end

      WRITE: begin
        if (slot_hit(bus.slot_tick, bus.slot_col, bus.slot_row,
                     cur_col_reg, cur_row_reg)) begin
          wr_hit = 1'b1;
          if (cur_col_reg < LAST_COL) begin
            cur_col_next = cur_col_reg + 6'd1;
            state_next   = IDLE;
          end else begin
            cur_col_next = 6'd0;
            cur_row_next = nl_row;
            if (nl_scroll) begin
              top_row_next = row_inc(top_row_reg);
              state_next   = CLEAR_LINE;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end

      CLEAR_LINE: begin
        if (bus.slot_tick && bus.slot_row == cur_row_reg) begin
          wr_hit = 1'b1;
          if (cnt_reg == LAST_LINE) begin
            cnt_next   = 10'd0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 10'd1;
          end
        end
      end

      default: state_next = CLEAR_ALL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= CLEAR_ALL;
      top_row_reg    <= 5'd0;
      cur_col_reg    <= 6'd0;
      cur_row_reg    <= 5'd0;
      code_reg       <= CH_SPACE;
      cnt_reg        <= 10'd0;
      char_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      top_row_reg    <= top_row_next;
      cur_col_reg    <= cur_col_next;
      cur_row_reg    <= cur_row_next;
      code_reg       <= code_next;
      cnt_reg        <= cnt_next;
      char_ready_reg <= (state_next == IDLE);
    end
  end

  // Reset masks the decode so a write pending in the old state cannot land.
  assign bus.mem_rc     = ~(wr_hit & ~reset);
  assign bus.mem_data   = (state_reg == WRITE) ? code_reg : CH_SPACE;
  assign bus.char_ready = char_ready_reg;
  assign top_row        = top_row_reg;
  assign cur_col        = cur_col_reg;
  assign cur_row        = cur_row_reg;

endmodule
